// File: rtl/env_rate_gen.sv
// env_rate_gen
//   Multi-operator envelope rate generator. Each operator has its own phase
//   accumulator. Accumulators are time-multiplexed by op_num. On each sample
//   strobe the addressed accumulator advances by a key-scaled effective rate.
//   The carry-out above COUNTER_WIDTH is reported to the envelope generator
//   as the number of envelope steps to take.
//
//   Pipeline: stage 1 registers the strobe, the operator, key_on, a
//   rate-is-zero flag and the increment. Stage 2 does the read-modify-write
//   of the accumulator and registers the outputs. Results appear 2 clocks
//   after the strobe.
//
// Ports
//   clk                    in   1          system clock
//   rst_n                  in   1          asynchronous active-low reset
//   sample_clk_en          in   1          update strobe for op_num
//   op_num                 in   OPW        operator addressed this cycle
//   ksr                    in   1          key scale rate
//   nts                    in   1          keyboard split: 1 = fnum[8], 0 = fnum[9]
//   fnum                   in   10         F-number
//   block                  in   3          octave
//   requested_rate         in   4          AR/DR/RR nibble, 0 = stopped
//   key_on                 in   1          restart: clear accumulator of op_num
//   rate_counter_overflow  out  OVF_WIDTH  envelope steps, registered
//   overflow_valid         out  1          1-cycle pulse, outputs valid
//   overflow_op            out  OPW        operator the pulse refers to
//   dbg_op                 in   OPW        (ENV_RATE_DBG_EN only) debug read address
//   dbg_acc                out  CW         (ENV_RATE_DBG_EN only) acc[dbg_op], 1-cycle latency
//
// Optional feature macro: ENV_RATE_DBG_EN. When it is defined, the module
// adds the debug accumulator read port.

module env_rate_gen #(
  parameter int NUM_OPS       = 18,
  parameter int COUNTER_WIDTH = 15,
  parameter int RATE_MAX      = 60,
  parameter int OVF_WIDTH     = 3,
  localparam int OPW          = (NUM_OPS > 1) ? $clog2(NUM_OPS) : 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     sample_clk_en,
  input  logic [OPW-1:0]           op_num,
  input  logic                     ksr,
  input  logic                     nts,
  input  logic [9:0]               fnum,
  input  logic [2:0]               block,
  input  logic [3:0]               requested_rate,
  input  logic                     key_on,
`ifdef ENV_RATE_DBG_EN
  input  logic [OPW-1:0]           dbg_op,
  output logic [COUNTER_WIDTH-1:0] dbg_acc,
`endif
  output logic [OVF_WIDTH-1:0]     rate_counter_overflow,
  output logic                     overflow_valid,
  output logic [OPW-1:0]           overflow_op
);

  localparam int SUMW = COUNTER_WIDTH + OVF_WIDTH;
  localparam logic [OPW:0] NUM_OPS_L  = (OPW+1)'(NUM_OPS);
  localparam logic [6:0]   RATE_MAX_L = 7'(RATE_MAX);

  // Only fnum[9:8] take part in key scaling.
  logic unused_fnum;
  assign unused_fnum = ^fnum[7:0];

  // ---------------------------------------------------------------------
  // Stage 1: effective rate and increment
  // ---------------------------------------------------------------------
  logic            ksel;
  logic [3:0]      k_d;
  logic [3:0]      ks_d;
  logic [6:0]      eff_sum;
  logic [5:0]      eff_d;
  logic [SUMW-1:0] incr_d;
  logic            op_ok;

  always_comb begin
    ksel    = nts ? fnum[8] : fnum[9];
    k_d     = {block, ksel};
    ks_d    = ksr ? k_d : (k_d >> 2);
    // This sum is 7 bits wide so that the clamp detects values up to 75.
    eff_sum = {3'b000, ks_d} + {1'b0, requested_rate, 2'b00};
    eff_d   = (eff_sum > RATE_MAX_L) ? RATE_MAX_L[5:0] : eff_sum[5:0];
    // The mantissa is 1.xx from eff[1:0]. The exponent is eff[5:2].
    incr_d  = {{(SUMW-3){1'b0}}, 1'b1, eff_d[1:0]} << eff_d[5:2];
    op_ok   = ({1'b0, op_num} < NUM_OPS_L);
  end

  logic            s1_valid_q;
  logic [OPW-1:0]  s1_op_q;
  logic            s1_key_q;
  logic            s1_zero_q;
  logic [SUMW-1:0] s1_incr_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s1_op_q    <= '0;
      s1_key_q   <= 1'b0;
      s1_zero_q  <= 1'b0;
      s1_incr_q  <= '0;
    end else begin
      s1_valid_q <= sample_clk_en && op_ok;
      if (sample_clk_en && op_ok) begin
        s1_op_q   <= op_num;
        s1_key_q  <= key_on;
        s1_zero_q <= (requested_rate == 4'd0);
        s1_incr_q <= incr_d;
      end
    end
  end

  // ---------------------------------------------------------------------
  // Stage 2: accumulator read-modify-write
  // ---------------------------------------------------------------------
  // The accumulator is read directly from the register array in the same
  // cycle as the write. A strobe for the same operator in the next cycle
  // therefore sees the updated value, and no bypass path is needed.
  logic [COUNTER_WIDTH-1:0] acc_q [NUM_OPS];

  logic [SUMW-1:0]          sum_d;
  logic                     acc_we_d;
  logic [COUNTER_WIDTH-1:0] acc_wr_d;
  logic [OVF_WIDTH-1:0]     ovf_d;

  always_comb begin
    sum_d    = {{OVF_WIDTH{1'b0}}, acc_q[s1_op_q]} + s1_incr_q;
    acc_we_d = 1'b0;
    acc_wr_d = '0;
    ovf_d    = '0;
    if (s1_key_q) begin
      // key_on takes priority over the increment.
      acc_we_d = 1'b1;
      acc_wr_d = '0;
    end else if (!s1_zero_q) begin
      acc_we_d = 1'b1;
      acc_wr_d = sum_d[COUNTER_WIDTH-1:0];
      ovf_d    = sum_d[SUMW-1:COUNTER_WIDTH];
    end
  end

  logic [OVF_WIDTH-1:0] ovf_q;
  logic                 valid_q;
  logic [OPW-1:0]       op_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < unsigned'(NUM_OPS); i++) begin
        acc_q[i] <= '0;
      end
      ovf_q   <= '0;
      valid_q <= 1'b0;
      op_q    <= '0;
    end else begin
      valid_q <= s1_valid_q;
      if (s1_valid_q) begin
        op_q  <= s1_op_q;
        ovf_q <= ovf_d;
        if (acc_we_d) begin
          acc_q[s1_op_q] <= acc_wr_d;
        end
      end
    end
  end

  assign rate_counter_overflow = ovf_q;
  assign overflow_valid        = valid_q;
  assign overflow_op           = op_q;

`ifdef ENV_RATE_DBG_EN
  // ---------------------------------------------------------------------
  // Debug read port: registered, returns 0 for an out-of-range address
  // ---------------------------------------------------------------------
  logic [COUNTER_WIDTH-1:0] dbg_acc_q;
  logic                     dbg_ok;

  always_comb begin
    dbg_ok = ({1'b0, dbg_op} < NUM_OPS_L);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dbg_acc_q <= '0;
    end else begin
      dbg_acc_q <= dbg_ok ? acc_q[dbg_op] : '0;
    end
  end

  assign dbg_acc = dbg_acc_q;
`endif

endmodule

// File: tb/tb_env_rate_gen.sv
// tb_env_rate_gen
//   Bench for env_rate_gen in the default configuration.
//   Expected overflow results are computed from the rate rules with integer
//   arithmetic, then queued. A monitor pops the queue on each valid pulse
//   and compares against it.

module tb_env_rate_gen;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       sample_clk_en;
  logic [4:0] op_num;
  logic       ksr;
  logic       nts;
  logic [9:0] fnum;
  logic [2:0] block;
  logic [3:0] requested_rate;
  logic       key_on;
  logic [2:0] rate_counter_overflow;
  logic       overflow_valid;
  logic [4:0] overflow_op;

  env_rate_gen #(
    .NUM_OPS      (18),
    .COUNTER_WIDTH(15),
    .RATE_MAX     (60),
    .OVF_WIDTH    (3)
  ) dut (
    .clk                  (clk),
    .rst_n                (rst_n),
    .sample_clk_en        (sample_clk_en),
    .op_num               (op_num),
    .ksr                  (ksr),
    .nts                  (nts),
    .fnum                 (fnum),
    .block                (block),
    .requested_rate       (requested_rate),
    .key_on               (key_on),
    .rate_counter_overflow(rate_counter_overflow),
    .overflow_valid       (overflow_valid),
    .overflow_op          (overflow_op)
  );

  always #5 clk = ~clk;

  typedef struct {
    int op;
    int ovf;
  } exp_t;

  exp_t exp_q[$];
  int   acc_m[18];
  int   checks    = 0;
  int   failures  = 0;
  int   valid_cnt = 0;
  int   last_ovf  = 0;
  int   last_op   = 0;

  task automatic chk(input string name, input int got, input int req);
    checks++;
    if (got != req) begin
      failures++;
      $display("FAIL %s got=%0d required=%0d at %0t", name, got, req, $time);
    end
  endtask

  // Reference model: applies the rate rules to one strobe.
  task automatic model(input int op, input bit ksr_v, input bit nts_v,
                       input logic [9:0] fnum_v, input logic [2:0] blk,
                       input logic [3:0] rate, input bit kon);
    int ksel, k, ks, eff, incr, total, o;
    exp_t e;
    if (op >= 18) return;
    ksel = nts_v ? int'(fnum_v[8]) : int'(fnum_v[9]);
    k    = int'(blk) * 2 + ksel;
    ks   = ksr_v ? k : k / 4;
    eff  = ks + int'(rate) * 4;
    if (eff > 60) eff = 60;
    incr = (4 + eff % 4) * (1 << (eff / 4));
    if (kon) begin
      acc_m[op] = 0;
      o = 0;
    end else if (rate == 4'd0) begin
      o = 0;
    end else begin
      total     = acc_m[op] + incr;
      o         = total / 32768;
      acc_m[op] = total % 32768;
    end
    e.op  = op;
    e.ovf = o;
    exp_q.push_back(e);
  endtask

  // Called at posedge+1. Drives one strobe and returns at the next posedge+1.
  task automatic issue(input int op, input bit ksr_v, input bit nts_v,
                       input logic [9:0] fnum_v, input logic [2:0] blk,
                       input logic [3:0] rate, input bit kon);
    sample_clk_en  = 1'b1;
    op_num         = 5'(op);
    ksr            = ksr_v;
    nts            = nts_v;
    fnum           = fnum_v;
    block          = blk;
    requested_rate = rate;
    key_on         = kon;
    model(op, ksr_v, nts_v, fnum_v, blk, rate, kon);
    @(posedge clk);
    #1;
    sample_clk_en = 1'b0;
    key_on        = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 20) begin
      idle(1);
      n++;
    end
    idle(2);
    chk(name, exp_q.size(), 0);
  endtask

  // Monitor: on a valid pulse, pop and compare. Otherwise check that the
  // outputs hold their last value.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n) begin
      if (overflow_valid) begin
        valid_cnt++;
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_valid op=%0d ovf=%0d required=no_pulse at %0t",
                   overflow_op, rate_counter_overflow, $time);
        end else begin
          e = exp_q.pop_front();
          chk("overflow", int'(rate_counter_overflow), e.ovf);
          chk("overflow_op", int'(overflow_op), e.op);
        end
        last_ovf = int'(rate_counter_overflow);
        last_op  = int'(overflow_op);
      end else begin
        chk("hold_ovf", int'(rate_counter_overflow), last_ovf);
        chk("hold_op", int'(overflow_op), last_op);
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired at %0t", $time);
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks + 1, failures);
    $fatal(1, "watchdog");
  end

  initial begin
    int vc;
    rst_n = 1'b0;
    sample_clk_en = 1'b0;
    op_num = '0; ksr = 1'b0; nts = 1'b0; fnum = '0; block = '0;
    requested_rate = '0; key_on = 1'b0;
    foreach (acc_m[i]) acc_m[i] = 0;
    #1;
    chk("reset_ovf", int'(rate_counter_overflow), 0);
    chk("reset_valid", int'(overflow_valid), 0);
    chk("reset_op", int'(overflow_op), 0);
    #20 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Test 1: rate 4, slowest path. 512 strobes give a single overflow.
    for (int i = 0; i < 512; i++) issue(2, 0, 0, 10'h000, 3'd0, 4'd4, 0);
    drain("drain_t1");

    // Test 2: effective rate clamps to 60, so each strobe gives overflow 4.
    for (int i = 0; i < 6; i++) issue(1, 1, 0, 10'h200, 3'd7, 4'd15, 0);
    drain("drain_t2");

    // Tests 3 and 4: eff 55, then key_on restart.
    issue(4, 1, 0, 10'h200, 3'd1, 4'd13, 0);
    issue(4, 1, 0, 10'h200, 3'd1, 4'd13, 0);
    issue(4, 1, 0, 10'h200, 3'd1, 4'd13, 0);
    issue(4, 1, 0, 10'h200, 3'd1, 4'd13, 1);
    issue(4, 1, 0, 10'h200, 3'd1, 4'd13, 0);
    drain("drain_t34");

    // Test 5: interleaved operators, then the same operator back-to-back.
    for (int i = 0; i < 40; i++) begin
      if (i % 2 == 0) issue(0, 0, 0, 10'h000, 3'd0, 4'd4, 0);
      else            issue(17, 1, 0, 10'h200, 3'd1, 4'd13, 0);
    end
    for (int i = 0; i < 8; i++) issue(3, 1, 1, 10'h100, 3'd2, 4'd12, 0);
    drain("drain_t5");

    // Test 6: out-of-range operator strobes produce no pulse.
    vc = valid_cnt;
    issue(18, 1, 0, 10'h200, 3'd7, 4'd15, 1);
    issue(31, 1, 0, 10'h200, 3'd7, 4'd15, 0);
    idle(4);
    chk("no_valid_bad_op", valid_cnt, vc);

    // Rate 0 pulses with overflow 0 and leaves the accumulator unchanged.
    issue(7, 1, 0, 10'h200, 3'd1, 4'd13, 0);
    issue(7, 1, 0, 10'h200, 3'd1, 4'd0, 0);
    issue(7, 1, 0, 10'h200, 3'd1, 4'd13, 0);
    drain("drain_rate0");

    // Asynchronous reset while a strobe is in flight.
    issue(5, 1, 0, 10'h200, 3'd7, 4'd15, 0);
    idle(3);
    issue(6, 1, 0, 10'h200, 3'd7, 4'd15, 0);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_ovf", int'(rate_counter_overflow), 0);
    chk("async_rst_valid", int'(overflow_valid), 0);
    chk("async_rst_op", int'(overflow_op), 0);
    exp_q.delete();
    foreach (acc_m[i]) acc_m[i] = 0;
    last_ovf = 0;
    last_op  = 0;
    #13 rst_n = 1'b1;
    @(posedge clk);
    #1;
    // The accumulators restart from 0 after reset.
    issue(6, 1, 0, 10'h200, 3'd1, 4'd13, 0);
    issue(6, 1, 0, 10'h200, 3'd1, 4'd13, 0);
    drain("drain_post_reset");

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 3) == 0) idle(1);
      issue(int'($urandom_range(0, 19)), 1'($urandom), 1'($urandom),
            10'($urandom), 3'($urandom), 4'($urandom_range(0, 15)),
            $urandom_range(0, 15) == 0);
    end
    drain("drain_random");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
